mult3_ctrl: RTL and testbench
=============================

MULT3_CTRL -- requirements
Module: mult3_ctrl

Interface
REQ-001 Parameter WIDTH, default 3: multiplier width; multiplicand and product are 2*WIDTH bits.
REQ-002 Parameter CNT_W, default 2: width of the datapath iteration counter.
REQ-003 clk  input  1: single clock, rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 in_valid  input  1, and in_ready  output  1: operand handshake.
REQ-006 in_m  input  WIDTH, and in_M  input  2*WIDTH: operands, sampled on handshake.
REQ-007 m  output  WIDTH, and M  output  2*WIDTH: registered operands driven to the shift-add datapath.
REQ-008 s1  output  1: datapath load; loads m/M and clears R and the counter.
REQ-009 s2  output  1: datapath add-select; 1 = R+M, 0 = R hold.
REQ-010 en1  output  1: enables the R register.
REQ-011 en2  output  1: shifts m right, M left, and increments the counter.
REQ-012 ProxBit_m  input  1: LSB of the datapath m register.
REQ-013 CountOut  input  CNT_W: datapath iteration count.
REQ-014 R  input  2*WIDTH: datapath product.
REQ-015 out_valid  output  1, and out_ready  input  1: result handshake.
REQ-016 out_R  output  2*WIDTH: registered product.
REQ-017 busy  output  1: high in any state except IDLE.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, CALC, SHIFT, CAPTURE and DONE.
REQ-019 IDLE: in_ready=1; an in_valid&in_ready edge SHALL latch in_m/in_M into m/M and go to LOAD.
REQ-020 LOAD: s1=1 for exactly one cycle, then go to CALC.
REQ-021 CALC: en1=1 and s2=ProxBit_m, then go to SHIFT.
REQ-022 SHIFT: en2=1; if CountOut==WIDTH-1, go to CAPTURE, otherwise go to CALC.
REQ-023 CAPTURE: out_R<=R, then go to DONE.
REQ-024 DONE: out_valid=1, with out_R and out_valid held stable until out_ready; on out_valid&out_ready go to IDLE.
REQ-025 Control outputs s1/s2/en1/en2 SHALL be 0 in every state not listed above for them, and are decoded from registered state only.
REQ-026 Latency: out_valid SHALL rise exactly 2*WIDTH+3 cycles after the accepting edge (9 for WIDTH=3).
REQ-027 in_ready SHALL be 0 from LOAD through DONE; no second operand is accepted while busy.
REQ-028 A DONE cycle with out_ready=1 and in_valid=1 SHALL accept the new operand on the following IDLE cycle, not the same cycle.
REQ-029 Products SHALL be unsigned; the datapath does not overflow because WIDTH x WIDTH fits 2*WIDTH.

Reset
REQ-030 reset low SHALL immediately force state=IDLE.
REQ-031 reset low SHALL immediately force m, M, out_R, s1, s2, en1, en2, out_valid and busy to 0, and in_ready to 0 while reset is held.
REQ-032 Reset mid-operation SHALL discard the operation; in_ready=1 on the first cycle after reset releases.

Configuration
REQ-033 Macro MULT3_CTRL_ZERO_SKIP_EN defined: accepting in_m==0 SHALL go directly IDLE->CAPTURE with out_R<=0.
REQ-034 With MULT3_CTRL_ZERO_SKIP_EN defined, the zero-skip path SHALL pulse no s1/en1/en2 and SHALL raise out_valid 2 cycles after accept.
REQ-035 Macro MULT3_CTRL_ZERO_SKIP_EN undefined: in_m==0 SHALL run the full sequence with s2=0 in every CALC.

Structure
REQ-036 Package mult3_pkg SHALL hold the WIDTH/CNT_W defaults and the state enum typedef.
REQ-037 Sub-module mult3_out_reg SHALL implement the out_R/out_valid holding register and out handshake; the FSM stays in mult3_ctrl.

Verification
REQ-038 Stimulus m=1, M=4 -> out_R=4, out_valid at cycle 9 after accept, one s1 pulse, three en2 pulses, one CALC with s2=1.
REQ-039 Stimulus m=7, M=7 -> out_R=49; s2=1 in all three CALC cycles.
REQ-040 Stimulus m=3, M=5 with out_ready held low 5 cycles -> out_R=15 stable, out_valid=1, in_ready=0 throughout; IDLE follows the release.
REQ-041 Stimulus: reset pulled low in the second CALC cycle -> all outputs 0 asynchronously; after release in_ready=1, and a following m=2, M=3 yields 6.
REQ-042 Stimulus m=0, M=5 -> out_R=0; with MULT3_CTRL_ZERO_SKIP_EN, out_valid at cycle 2 and no en pulses; without it, out_valid at cycle 9 and s2 never 1.
REQ-043 Stimulus: back-to-back operands (1,4) then (2,6) with in_valid and out_ready held high -> results 4 then 12, second accept one cycle after the first DONE.

Source files
------------

// File: rtl/mult3_pkg.sv
// Shared defaults and FSM state type for the mult3 shift-add controller.
// Optional zero-skip fast path is enabled by MULT3_CTRL_ZERO_SKIP_EN.
package mult3_pkg;

  localparam int MULT3_WIDTH = 3;
  localparam int MULT3_CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CALC    = 3'd2,
    SHIFT   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/mult3_if.sv
// Operand/result handshake bundle between a requester and mult3_ctrl.
// Master drives operands and out_ready; slave is the controller.
interface mult3_if
  import mult3_pkg::*;
#(
  parameter int WIDTH = MULT3_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_m;
  logic [2*WIDTH-1:0] in_M;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_R;
  logic               busy;

  modport master (
    output in_valid,
    output in_m,
    output in_M,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_R,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_m,
    input  in_M,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_R,
    output busy
  );

endinterface

// File: rtl/mult3_out_reg.sv
// Result holding register: captures the product and holds it with
// out_valid until the consumer takes it.
module mult3_out_reg
  import mult3_pkg::*;
#(
  parameter int W = 2 * MULT3_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         capture,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_R
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_R     <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_R     <= d;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mult3_ctrl.sv
// Control FSM for a shift-add multiplier datapath with valid/ready I/O.
// Define MULT3_CTRL_ZERO_SKIP_EN to short-circuit in_m==0 to CAPTURE.
module mult3_ctrl
  import mult3_pkg::*;
#(
  parameter int WIDTH = MULT3_WIDTH,
  parameter int CNT_W = MULT3_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  mult3_if.slave             bus,
  output logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] M,
  output logic               s1,
  output logic               s2,
  output logic               en1,
  output logic               en2,
  input  logic               ProxBit_m,
  input  logic [CNT_W-1:0]   CountOut,
  input  logic [2*WIDTH-1:0] R
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state;
  state_e             nxt;
  logic               accept;
  logic               last;
  logic               capture;
  logic [2*WIDTH-1:0] cap_d;

  assign accept  = bus.in_valid & bus.in_ready;
  assign last    = (CountOut == LAST_CNT);
  assign capture = (state == CAPTURE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef MULT3_CTRL_ZERO_SKIP_EN
          nxt = (bus.in_m == '0) ? CAPTURE : LOAD;
`else
          nxt = LOAD;
`endif
        end
      end
      LOAD:    nxt = CALC;
      CALC:    nxt = SHIFT;
      SHIFT:   nxt = last ? CAPTURE : CALC;
      CAPTURE: nxt = DONE;
      DONE:    nxt = (bus.out_valid & bus.out_ready) ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m <= '0;
      M <= '0;
    end else if (accept) begin
      m <= bus.in_m;
      M <= bus.in_M;
    end
  end

  // Skipped operations never clear the datapath R, so force zero here.
`ifdef MULT3_CTRL_ZERO_SKIP_EN
  assign cap_d = (m == '0) ? '0 : R;
`else
  assign cap_d = R;
`endif

  assign s1  = (state == LOAD);
  assign en1 = (state == CALC);
  assign s2  = (state == CALC) & ProxBit_m;
  assign en2 = (state == SHIFT);

  assign bus.in_ready = (state == IDLE) & reset;
  assign bus.busy     = (state != IDLE);

  mult3_out_reg #(
    .W(2 * WIDTH)
  ) u_out (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .d         (cap_d),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_R     (bus.out_R)
  );

endmodule

// File: tb/tb_mult3_ctrl.sv
// Directed bench for mult3_ctrl with a behavioural shift-add datapath.
// Expected products and latencies are hand-computed constants.
module tb_mult3_ctrl;
  import mult3_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] m;
  logic [5:0] M;
  logic       s1, s2, en1, en2;
  logic [2:0] dm;
  logic [5:0] dM;
  logic [5:0] dR;
  logic [1:0] dcnt;

  int tests;
  int fails;
  int n_s1, n_s2, n_en1, n_en2;

  mult3_if #(.WIDTH(3)) bus ();

  mult3_ctrl #(
    .WIDTH(3),
    .CNT_W(2)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .m         (m),
    .M         (M),
    .s1        (s1),
    .s2        (s2),
    .en1       (en1),
    .en2       (en2),
    .ProxBit_m (dm[0]),
    .CountOut  (dcnt),
    .R         (dR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (s1) begin
      dm   <= m;
      dM   <= M;
      dR   <= '0;
      dcnt <= '0;
    end else begin
      if (en1 && s2) dR <= dR + dM;
      if (en2) begin
        dm   <= dm >> 1;
        dM   <= dM << 1;
        dcnt <= dcnt + 2'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (s1)  n_s1  = n_s1 + 1;
    if (s2)  n_s2  = n_s2 + 1;
    if (en1) n_en1 = n_en1 + 1;
    if (en2) n_en2 = n_en2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input int a, input int b, input int exp_r,
                        input int lat, input int e_s1, input int e_en1,
                        input int e_en2, input int e_s2, input int hold);
    int c;
    int b_s1, b_s2, b_en1, b_en2;
    bit seen;
    @(negedge clk);
    bus.in_m     = 3'(a);
    bus.in_M     = 6'(b);
    bus.in_valid = 1'b1;
    chk("accept ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    b_s1  = n_s1;
    b_s2  = n_s2;
    b_en1 = n_en1;
    b_en2 = n_en2;
    c     = 0;
    seen  = 1'b0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("latency", 32'(c), 32'(lat));
    chk("out_R", 32'(bus.out_R), 32'(exp_r));
    chk("s1 pulses", 32'(n_s1 - b_s1), 32'(e_s1));
    chk("en1 pulses", 32'(n_en1 - b_en1), 32'(e_en1));
    chk("en2 pulses", 32'(n_en2 - b_en2), 32'(e_en2));
    chk("s2 pulses", 32'(n_s2 - b_s2), 32'(e_s2));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold out_R", 32'(bus.out_R), 32'(exp_r));
      chk("hold valid", 32'(bus.out_valid), 1);
      chk("hold in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle ready", 32'(bus.in_ready), 1);
    chk("idle busy", 32'(bus.busy), 0);
    chk("idle valid", 32'(bus.out_valid), 0);
  endtask

  initial begin
    int c, first, acc2, second;
    tests         = 0;
    fails         = 0;
    n_s1          = 0;
    n_s2          = 0;
    n_en1         = 0;
    n_en2         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_m      = '0;
    bus.in_M      = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(bus.in_ready), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_R", 32'(bus.out_R), 0);
    chk("rst m", 32'(m), 0);
    chk("rst M", 32'(M), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst ready", 32'(bus.in_ready), 1);

    run_op(1, 4, 4, 9, 1, 3, 3, 1, 0);
    run_op(7, 7, 49, 9, 1, 3, 3, 3, 0);
    run_op(3, 5, 15, 9, 1, 3, 3, 2, 5);

    // Reset dropped during the second CALC cycle.
    @(negedge clk);
    bus.in_m     = 3'd5;
    bus.in_M     = 6'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-rst en1", 32'(en1), 1);
    rst_n = 1'b0;
    #1;
    chk("arst s1", 32'(s1), 0);
    chk("arst s2", 32'(s2), 0);
    chk("arst en1", 32'(en1), 0);
    chk("arst en2", 32'(en2), 0);
    chk("arst m", 32'(m), 0);
    chk("arst M", 32'(M), 0);
    chk("arst out_R", 32'(bus.out_R), 0);
    chk("arst valid", 32'(bus.out_valid), 0);
    chk("arst busy", 32'(bus.busy), 0);
    chk("arst in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel in_ready", 32'(bus.in_ready), 1);
    run_op(2, 3, 6, 9, 1, 3, 3, 1, 0);

`ifdef MULT3_CTRL_ZERO_SKIP_EN
    run_op(0, 5, 0, 2, 0, 0, 0, 0, 0);
`else
    run_op(0, 5, 0, 9, 1, 3, 3, 0, 0);
`endif

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    bus.in_m      = 3'd1;
    bus.in_M      = 6'd4;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_m = 3'd2;
    bus.in_M = 6'd6;
    c        = 0;
    first    = -1;
    acc2     = -1;
    second   = -1;
    while (second < 0 && c < 60) begin
      @(negedge clk);
      c++;
      if (acc2 >= 0 && bus.in_valid) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        if (first < 0) begin
          first = c;
          chk("b2b first R", 32'(bus.out_R), 4);
        end else if (acc2 >= 0) begin
          second = c;
          chk("b2b second R", 32'(bus.out_R), 12);
        end
      end
      if (first >= 0 && acc2 < 0 && bus.in_ready) acc2 = c;
    end
    chk("b2b first lat", 32'(first), 9);
    chk("b2b accept2", 32'(acc2), 10);
    chk("b2b second lat", 32'(second), 19);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("b2b idle", 32'(bus.in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
